// File: rtl/ffo_pkg.sv
// Shared types and helpers for the find-first-one scan sequencer.
package ffo_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLaunch,
    StWait,
    StEmit,
    StDone,
    StErr
  } state_e;

  localparam int unsigned DefaultN = 32;

  typedef logic [0:$clog2(DefaultN)-1] pos_t;

  function automatic int unsigned timeout_cycles(input int unsigned n);
    return 2 * n + 4;
  endfunction

endpackage

// File: rtl/ffo_scan_sequencer.sv
// Enumerates every set bit of a vector by repeatedly launching an external FFO engine,
// clearing each found bit and streaming its position out; owns the engine-ready watchdog.
module ffo_scan_sequencer
  import ffo_pkg::*;
#(
  parameter int unsigned N       = 32,
  parameter int unsigned PW      = $clog2(N),
  parameter int unsigned TIMEOUT = timeout_cycles(N)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [0:N-1]  in_vec_i,
  output logic          ffo_start_o,
  output logic [0:N-1]  ffo_b_o,
  input  logic [0:PW-1] ffo_p_i,
  input  logic          ffo_ready_i,
  output logic          pos_valid_o,
  input  logic          pos_ready_i,
  output logic [0:PW-1] pos_o,
  output logic          pos_last_o,
  output logic          done_o,
  output logic [PW:0]   count_o,
  output logic          err_o
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam int unsigned CW = PW + 1;

  state_e        state_q, state_d;
  logic [0:N-1]  work_q, work_d;
  logic [0:N-1]  cleared;
  logic [0:PW-1] pos_q, pos_d;
  logic          pos_valid_q, pos_valid_d;
  logic          pos_last_q, pos_last_d;
  logic [CW-1:0] count_q, count_d;
  logic          err_q, err_d;
  logic [TW-1:0] timer_q, timer_d;

  always_comb begin
    state_d     = state_q;
    work_d      = work_q;
    pos_d       = pos_q;
    pos_valid_d = pos_valid_q;
    pos_last_d  = pos_last_q;
    count_d     = count_q;
    err_d       = err_q;
    timer_d     = timer_q;
    cleared          = work_q;
    cleared[ffo_p_i] = 1'b0;

    unique case (state_q)
      StIdle: begin
        timer_d = '0;
        if (in_valid_i) begin
          work_d  = in_vec_i;
          count_d = '0;
          // A zero vector never reaches the engine: its result would be undefined.
          state_d = (in_vec_i == '0) ? StDone : StLaunch;
        end
      end
      StLaunch: begin
        // The launch cycle counts toward the watchdog so err lands TIMEOUT cycles after start.
        timer_d = TW'(1);
        state_d = StWait;
      end
      StWait: begin
        if (ffo_ready_i) begin
          pos_d       = ffo_p_i;
          pos_valid_d = 1'b1;
          work_d      = cleared;
          pos_last_d  = (cleared == '0);
          state_d     = StEmit;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = StErr;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      StEmit: begin
        if (pos_ready_i) begin
          pos_valid_d = 1'b0;
          count_d     = count_q + CW'(1);
          state_d     = pos_last_q ? StDone : StLaunch;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      StErr: begin
        pos_valid_d = 1'b0;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      work_q      <= '0;
      pos_q       <= '0;
      pos_valid_q <= 1'b0;
      pos_last_q  <= 1'b0;
      count_q     <= '0;
      err_q       <= 1'b0;
      timer_q     <= '0;
    end else begin
      state_q     <= state_d;
      work_q      <= work_d;
      pos_q       <= pos_d;
      pos_valid_q <= pos_valid_d;
      pos_last_q  <= pos_last_d;
      count_q     <= count_d;
      err_q       <= err_d;
      timer_q     <= timer_d;
    end
  end

  assign in_ready_o  = (state_q == StIdle);
  assign ffo_start_o = (state_q == StLaunch);
  assign ffo_b_o     = work_q;
  assign pos_valid_o = pos_valid_q;
  assign pos_o       = pos_q;
  assign pos_last_o  = pos_last_q;
  assign done_o      = (state_q == StDone);
  assign count_o     = count_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_ffo_scan_sequencer.sv
// Directed and randomized bench for ffo_scan_sequencer with a behavioural FFO engine beside it.
module tb_ffo_scan_sequencer;

  localparam int N  = 32;
  localparam int PW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [0:N-1]  in_vec;
  logic          ffo_start;
  logic [0:N-1]  ffo_b;
  logic [0:PW-1] ffo_p;
  logic          ffo_ready;
  logic          pos_valid;
  logic          pos_ready;
  logic [0:PW-1] pos;
  logic          pos_last;
  logic          done;
  logic [PW:0]   count;
  logic          err;

  int n_cmp = 0;
  int n_bad = 0;

  ffo_scan_sequencer #(.N(N)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .in_vec_i   (in_vec),
    .ffo_start_o(ffo_start),
    .ffo_b_o    (ffo_b),
    .ffo_p_i    (ffo_p),
    .ffo_ready_i(ffo_ready),
    .pos_valid_o(pos_valid),
    .pos_ready_i(pos_ready),
    .pos_o      (pos),
    .pos_last_o (pos_last),
    .done_o     (done),
    .count_o    (count),
    .err_o      (err)
  );

  always #5 clk = ~clk;

  // Engine model: drops ready when it samples start, answers the greatest set index later.
  bit           eng_hang = 1'b0;
  int           eng_cnt;
  logic [0:N-1] eng_b;

  function automatic int top_bit(input logic [0:N-1] b);
    int r = 0;
    for (int i = 0; i < N; i++) if (b[i]) r = i;
    return r;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      ffo_ready <= 1'b1;
      ffo_p     <= '0;
      eng_cnt   <= 0;
      eng_b     <= '0;
    end else if (ffo_start) begin
      ffo_ready <= 1'b0;
      eng_cnt   <= int'($urandom_range(1, 4));
      eng_b     <= ffo_b;
    end else if (eng_cnt > 0) begin
      eng_cnt <= eng_cnt - 1;
      if (eng_cnt == 1 && !eng_hang) begin
        ffo_ready <= 1'b1;
        ffo_p     <= PW'(top_bit(eng_b));
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_ffo_start"}, ffo_start, 0);
    chk({tag, "_ffo_b"}, ffo_b, 0);
    chk({tag, "_pos_valid"}, pos_valid, 0);
    chk({tag, "_pos"}, pos, 0);
    chk({tag, "_pos_last"}, pos_last, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_count"}, count, 0);
    chk({tag, "_err"}, err, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_reset("reset");
    rst = 1'b0;
  endtask

  task automatic offer(input logic [0:N-1] v);
    int cyc = 0;
    while (!in_ready && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("offer_in_ready", in_ready, 1);
    in_vec   = v;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    in_vec   = '0;
  endtask

  // Expected stream: set indices in descending order, pos_last on the final one,
  // count tracks accepts, done one cycle after the final accept.
  task automatic scan(input logic [0:N-1] v, input int stall, input string tag);
    int q[$];
    int npos, w, got, starts, cyc, last_acc, done_cyc;
    bit pend;
    logic [0:PW-1] held;
    for (int i = N - 1; i >= 0; i--) if (v[i]) q.push_back(i);
    npos = q.size();
    pend = 1'b0; w = 0; got = 0; starts = 0; last_acc = 0; done_cyc = 0; held = '0;
    offer(v);
    cyc = 1;
    while (done_cyc == 0 && cyc < 3000) begin
      pos_ready = 1'b0;
      if (ffo_start) starts++;
      if (done) done_cyc = cyc;
      if (pos_valid) begin
        if (!pend) begin
          pend = 1'b1;
          held = pos;
          w    = stall;
        end else begin
          chk({tag, "_pos_stable"}, pos, held);
        end
        if (w > 0) begin
          w--;
        end else begin
          if (q.size() == 0) begin
            chk({tag, "_extra_pos"}, pos_valid, 0);
          end else begin
            chk({tag, "_count_run"}, count, got);
            chk({tag, "_pos"}, pos, q[0]);
            chk({tag, "_pos_last"}, pos_last, q.size() == 1);
            void'(q.pop_front());
          end
          got++;
          pos_ready = 1'b1;
          pend      = 1'b0;
          last_acc  = cyc;
        end
      end
      @(negedge clk);
      cyc++;
    end
    pos_ready = 1'b0;
    chk({tag, "_done_seen"}, done_cyc != 0, 1);
    chk({tag, "_left"}, q.size(), 0);
    chk({tag, "_starts"}, starts, npos);
    chk({tag, "_count"}, count, npos);
    if (npos > 0) chk({tag, "_done_gap"}, done_cyc - last_acc, 1);
    else chk({tag, "_done_gap0"}, done_cyc >= 1 && done_cyc <= 2, 1);
    chk({tag, "_done_width"}, done, 0);
    chk({tag, "_idle_ready"}, in_ready, 1);
    chk({tag, "_count_hold"}, count, npos);
  endtask

  initial begin
    logic [0:N-1] v;
    int k;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_vec    = '0;
    pos_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset("init");
    rst = 1'b0;

    scan(32'h0000_0001, 0, "t1_bit31");
    v = '0; v[0] = 1'b1; v[5] = 1'b1; v[31] = 1'b1;
    scan(v, 0, "t2_three");
    scan('0, 0, "t3_zero");
    scan('1, 5, "t4_ones");

    for (int r = 0; r < 8; r++) begin
      v = $urandom() & $urandom();
      scan(v, int'($urandom_range(0, 3)), "rnd");
    end

    // Reset while waiting on the engine, then restart cleanly.
    do_reset();
    v = '0; v[0] = 1'b1; v[31] = 1'b1;
    offer(v);
    k = 0;
    while (!ffo_start && k < 10) begin
      @(negedge clk);
      k++;
    end
    chk("t6_start", ffo_start, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_reset("t6_mid_reset");
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t6_no_stale_done", done, 0);
    end
    v = '0; v[7] = 1'b1;
    scan(v, 1, "t6_bit7");

    // Engine never answers: watchdog fires TIMEOUT cycles after start and sticks.
    eng_hang = 1'b1;
    v = '0; v[12] = 1'b1;
    offer(v);
    k = 0;
    while (!ffo_start && k < 10) begin
      @(negedge clk);
      k++;
    end
    chk("t5_start", ffo_start, 1);
    for (int c = 1; c <= 68; c++) begin
      @(negedge clk);
      if (c == 67) chk("t5_err_early", err, 0);
      if (c == 68) chk("t5_err", err, 1);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t5_in_ready", in_ready, 0);
      chk("t5_pos_valid", pos_valid, 0);
      chk("t5_err_sticky", err, 1);
    end
    eng_hang = 1'b0;
    do_reset();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
